// File: rtl/mspu_pkg.sv
// Shared types and constants for the writeback stage.
package mspu_pkg;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One outstanding load: destination, type and byte offset within the word.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } lq_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects byte/halfword from an aligned word and extends it.
module load_align
  import mspu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extend according to load type; unknown encodings pass the word.
  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {24'h000000, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {16'h0000, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates load responses and ALU results into one registered
// register-file write per cycle, tracks outstanding loads in order and flags hazards.
module reg_writeback
  import mspu_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [4:0]                  alu_rd,
  input  logic [31:0]                 alu_data,
  input  logic                        ld_issue_valid,
  output logic                        ld_issue_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [2:0]                  ld_funct3,
  input  logic [1:0]                  ld_offset,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  input  logic [4:0]                  chk_a,
  input  logic [4:0]                  chk_b,
  output logic                        hazard_a,
  output logic                        hazard_b,
  output logic [4:0]                  waddr,
  output logic [31:0]                 wdata,
  output logic                        reg_we,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic                        err_unexpected
);

  localparam int unsigned PtrW = $clog2(LQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  lq_entry_t             lq_q [LQ_DEPTH];
  lq_entry_t             lq_d [LQ_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  reg_we_q, reg_we_d;
  logic                  err_q, err_d;

  logic                  lq_empty;
  logic                  push;
  logic                  pop;
  logic                  alu_fire;
  lq_entry_t             head;
  logic [31:0]           ld_result;
  logic [PtrW-1:0]       rel;

  // Handshakes: a load response always beats the ALU; ready depends on state only.
  always_comb begin
    lq_empty       = (count_q == '0);
    ld_issue_ready = run && (count_q < CntW'(LQ_DEPTH));
    alu_ready      = run && !mem_rvalid;
    push           = ld_issue_valid && ld_issue_ready;
    pop            = run && mem_rvalid && !lq_empty;
    alu_fire       = alu_valid && alu_ready;
    head           = lq_q[rd_ptr_q];
  end

  load_align u_load_align (
    .funct3_i (head.funct3),
    .offset_i (head.offset),
    .rdata_i  (mem_rdata),
    .result_o (ld_result)
  );

  // Queue next state: circular buffer, pointers wrap naturally at power-of-two depth.
  always_comb begin
    lq_d     = lq_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      lq_d[wr_ptr_q] = '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};
      wr_ptr_d       = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Output register next state; x0 destinations still update address/data but never write.
  always_comb begin
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    reg_we_d = 1'b0;
    err_d    = err_q | (run && mem_rvalid && lq_empty);
    if (pop) begin
      waddr_d  = head.rd;
      wdata_d  = ld_result;
      reg_we_d = (head.rd != 5'd0);
    end else if (alu_fire) begin
      waddr_d  = alu_rd;
      wdata_d  = alu_data;
      reg_we_d = (alu_rd != 5'd0);
    end
  end

  // Hazards: any live queue entry, or the write currently presented to the register file.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    rel      = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      rel = PtrW'(i) - rd_ptr_q;
      if ({1'b0, rel} < count_q) begin
        if (lq_q[i].rd == chk_a) hazard_a = 1'b1;
        if (lq_q[i].rd == chk_b) hazard_b = 1'b1;
      end
    end
    if (reg_we_q && (waddr_q == chk_a)) hazard_a = 1'b1;
    if (reg_we_q && (waddr_q == chk_b)) hazard_b = 1'b1;
    if (chk_a == 5'd0) hazard_a = 1'b0;
    if (chk_b == 5'd0) hazard_b = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      reg_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      lq_q     <= lq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      reg_we_q <= reg_we_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    waddr          = waddr_q;
    wdata          = wdata_q;
    reg_we         = reg_we_q;
    lq_count       = count_q;
    err_unexpected = err_q;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: load-extraction table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_reg_writeback;
  import mspu_pkg::*;

  localparam int unsigned LQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  chk_a, chk_b;
  logic        hazard_a, hazard_b;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_we;
  logic [2:0]  lq_count;
  logic        err_unexpected;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_offset      (ld_offset),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .chk_a          (chk_a),
    .chk_b          (chk_b),
    .hazard_a       (hazard_a),
    .hazard_b       (hazard_b),
    .waddr          (waddr),
    .wdata          (wdata),
    .reg_we         (reg_we),
    .lq_count       (lq_count),
    .err_unexpected (err_unexpected)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } m_ent_t;

  ld_vec_t vecs [10];
  m_ent_t  mq [$];
  m_ent_t  e;
  logic    m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic    m_err;
  logic    can_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    alu_valid      = 1'b0;
    ld_issue_valid = 1'b0;
    mem_rvalid     = 1'b0;
  endtask

  // Reference extraction from the load rules using shifts and masks.
  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = longint'((rdata >> (8 * off)) & 32'hFF);
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((rdata >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  function automatic logic ref_hazard(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
    return m_we && (m_waddr == c);
  endfunction

  initial begin
    vecs[0] = '{F3_LB,  2'd2, 32'h0080_0000, 32'hFFFF_FF80};
    vecs[1] = '{F3_LBU, 2'd2, 32'h0080_0000, 32'h0000_0080};
    vecs[2] = '{F3_LH,  2'd2, 32'h8001_0000, 32'hFFFF_8001};
    vecs[3] = '{F3_LHU, 2'd3, 32'h8001_0000, 32'h0000_8001};
    vecs[4] = '{F3_LW,  2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{F3_LB,  2'd0, 32'h1234_567F, 32'h0000_007F};
    vecs[6] = '{F3_LB,  2'd3, 32'h80FF_FFFF, 32'hFFFF_FF80};
    vecs[7] = '{F3_LH,  2'd0, 32'h0000_7FFF, 32'h0000_7FFF};
    vecs[8] = '{3'b011, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[9] = '{F3_LBU, 2'd1, 32'h0000_AB00, 32'h0000_00AB};

    reset = 1'b0; run = 1'b0; quiet();
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0;
    mem_rdata = '0; chk_a = '0; chk_b = '0;
    tick(); tick();
    chk("rst_reg_we", reg_we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_lq_count", lq_count, 0);
    chk("rst_err", err_unexpected, 0);
    reset = 1'b1; run = 1'b1;

    // ALU only.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1 chk("alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("alu_we", reg_we, 1);
    chk("alu_waddr", waddr, 5);
    chk("alu_wdata", wdata, 32'h1234);
    tick();
    chk("alu_idle_we", reg_we, 0);

    // Load extraction table: issue, then respond next cycle.
    for (int i = 0; i < 10; i++) begin
      ld_issue_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = vecs[i].f3; ld_offset = vecs[i].off;
      tick();
      ld_issue_valid = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
      #1 chk("ld_alu_ready", alu_ready, 0);
      tick();
      mem_rvalid = 1'b0;
      chk("ld_we", reg_we, 1);
      chk("ld_waddr", waddr, 3);
      chk($sformatf("ld_wdata[%0d]", i), wdata, vecs[i].exp);
    end

    // Conflict: load response and ALU in the same cycle.
    ld_issue_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = F3_LW; ld_offset = 2'd0;
    tick();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hAAAA;
    #1 chk("cf_alu_ready0", alu_ready, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("cf_ld_waddr", waddr, 4);
    chk("cf_ld_wdata", wdata, 32'h1111_1111);
    #1 chk("cf_alu_ready1", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("cf_alu_waddr", waddr, 9);
    chk("cf_alu_wdata", wdata, 32'hAAAA);

    // Full queue, then push+pop at count 3.
    for (int i = 0; i < 4; i++) begin
      ld_issue_valid = 1'b1; ld_rd = 5'(10 + i); ld_funct3 = F3_LW;
      tick();
    end
    chk("full_count", lq_count, 4);
    chk("full_ready", ld_issue_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AA;
    tick();
    chk("full_pop_count", lq_count, 3);
    chk("full_pop_waddr", waddr, 10);
    chk("c3_ready", ld_issue_ready, 1);
    tick();
    chk("c3_pushpop_count", lq_count, 3);
    ld_issue_valid = 1'b0;
    tick(); tick(); tick();
    mem_rvalid = 1'b0;
    chk("drain_count", lq_count, 0);
    tick();

    // Hazard through pending load and the following write.
    ld_issue_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = F3_LW;
    tick();
    ld_issue_valid = 1'b0; chk_a = 5'd7; chk_b = 5'd0;
    #1 chk("hz_a_pending", hazard_a, 1);
    chk("hz_b_zero", hazard_b, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h7;
    #1 chk("hz_a_resp", hazard_a, 1);
    tick();
    mem_rvalid = 1'b0;
    chk("hz_a_write", hazard_a, 1);
    tick();
    chk("hz_a_clear", hazard_a, 0);
    chk_a = 5'd0;

    // Reset with loads queued, then an orphan response.
    ld_issue_valid = 1'b1; ld_rd = 5'd2;
    tick(); tick();
    ld_issue_valid = 1'b0;
    chk("pre_rst_count", lq_count, 2);
    reset = 1'b0;
    tick();
    chk("mid_rst_count", lq_count, 0);
    chk("mid_rst_we", reg_we, 0);
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("err_set", err_unexpected, 1);
    chk("err_no_write", reg_we, 0);
    tick();
    chk("err_sticky", err_unexpected, 1);

    // Randomized traffic against the reference model.
    reset = 1'b0; tick(); reset = 1'b1;
    mq.delete(); m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      run            = ($urandom_range(0, 9) != 0);
      alu_valid      = $urandom_range(0, 1) != 0;
      alu_rd         = 5'($urandom_range(0, 7));
      alu_data       = $urandom;
      ld_issue_valid = $urandom_range(0, 2) != 0;
      ld_rd          = 5'($urandom_range(0, 7));
      ld_funct3      = 3'($urandom_range(0, 7));
      ld_offset      = 2'($urandom_range(0, 3));
      mem_rvalid     = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      mem_rdata      = $urandom;
      chk_a          = 5'($urandom_range(0, 7));
      chk_b          = 5'($urandom_range(0, 7));
      #1;
      chk("r_alu_ready", alu_ready, run && !mem_rvalid);
      chk("r_ld_ready", ld_issue_ready, run && (mq.size() < LQ_DEPTH));
      chk("r_hazard_a", hazard_a, ref_hazard(chk_a));
      chk("r_hazard_b", hazard_b, ref_hazard(chk_b));
      m_we = 1'b0;
      if (run) begin
        can_push = mq.size() < LQ_DEPTH;
        if (mem_rvalid && mq.size() > 0) begin
          e = mq.pop_front();
          m_we = (e.rd != 0); m_waddr = e.rd; m_wdata = ref_extract(e.f3, e.off, mem_rdata);
        end else if (mem_rvalid) begin
          m_err = 1'b1;
        end else if (alu_valid) begin
          m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
        end
        if (ld_issue_valid && can_push) mq.push_back('{rd: ld_rd, f3: ld_funct3, off: ld_offset});
      end
      tick();
      chk("r_reg_we", reg_we, m_we);
      if (m_we) begin
        chk("r_waddr", waddr, m_waddr);
        chk("r_wdata", wdata, m_wdata);
      end
      chk("r_lq_count", lq_count, mq.size());
      chk("r_err", err_unexpected, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback stage directly upstream of the 32x32 register file; produces its `waddr`/`wdata`/`reg_we` write port.
- Merges ALU results and in-order load responses into one registered write per cycle.
- Tracks outstanding loads in a small in-order queue and reports read-after-load hazards to the operand-fetch stage.
- Performs load byte/halfword extraction and sign/zero extension.

Parameters:
- LQ_DEPTH, 4, maximum outstanding loads (power of two, >=2).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- run  in  1  core run enable; 0 freezes all state
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  load queue can accept
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
- ld_offset  in  2  byte address bits [1:0]
- mem_rvalid  in  1  load response valid (no backpressure)
- mem_rdata  in  32  aligned memory word
- chk_a  in  5  operand A register to check
- chk_b  in  5  operand B register to check
- hazard_a  out  1  chk_a has a pending write
- hazard_b  out  1  chk_b has a pending write
- waddr  out  5  register file write address
- wdata  out  32  register file write data
- reg_we  out  1  register file write enable
- lq_count  out  $clog2(LQ_DEPTH)+1  outstanding loads
- err_unexpected  out  1  sticky: response with empty queue

Behaviour:
- Reset:
  - While `reset==0` at a clk edge: queue flushed; `lq_count`=0; `reg_we`=0, `waddr`=0, `wdata`=0; `err_unexpected`=0.
  - Reset mid-operation discards queued loads. Responses arriving afterwards hit an empty queue and set the error.
- Freeze: when `run==0` and reset is inactive:
  - No push, pop or write.
  - `alu_ready`=0, `ld_issue_ready`=0.
  - `reg_we` registered to 0; `waddr`/`wdata` hold.
  - `mem_rvalid` is ignored. Upstream must not return data while frozen.
- Queue:
  - In-order FIFO of {rd, funct3, offset}.
  - `ld_issue_ready` = run && (lq_count < LQ_DEPTH). It depends on state only; there is no same-cycle pop-through when full.
  - Push on `ld_issue_valid && ld_issue_ready`.
  - Pop on `mem_rvalid` with a non-empty queue.
  - Simultaneous push and pop leaves `lq_count` unchanged; pointers wrap modulo LQ_DEPTH.
- Arbitration:
  - A load response always wins.
  - `alu_ready` = run && !mem_rvalid (combinational).
  - Exactly one source is registered to the output per cycle.
- Output registers: 1-cycle latency, for both sources.
  - Winner at cycle t drives `waddr`/`wdata` with `reg_we`=1 during cycle t+1.
  - `reg_we` is forced 0 when rd==0; the queue entry is still consumed.
  - With no winner, `reg_we`=0.
- Load extraction:
  - LB/LBU (000/100): byte `mem_rdata[8*offset +: 8]`, sign- or zero-extended.
  - LH/LHU (001/101): halfword `mem_rdata[16*offset[1] +: 16]`; `offset[0]` ignored.
  - LW (010) and any other encoding: full word.
- Hazards (combinational):
  - `hazard_x` = chk_x != 0 AND (any valid queue entry has rd==chk_x OR (`reg_we` && `waddr`==chk_x)).
  - A response popped at cycle t still flags through t+1 via the `reg_we` term.
  - ALU in-flight forwarding is upstream's responsibility.
- Errors: `mem_rvalid` with an empty queue sets `err_unexpected`; nothing is written, and the flag is cleared only by reset.

Decomposition:
- mspu_pkg:
  - load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - typedef `lq_entry_t` {rd[4:0], funct3[2:0], offset[1:0]}.
- One combinational sub-module `load_align` (funct3, offset, rdata -> 32-bit result) keeps extraction separately testable.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 -> alu_ready=1; next cycle reg_we=1, waddr=5, wdata=0x1234.
- Load extend:
  - Issue LB rd=3 offset=2, then mem_rdata=0x0080_0000 -> wdata=0xFFFF_FF80.
  - Same with LBU -> 0x0000_0080.
  - LH offset=2, rdata=0x8001_0000 -> 0xFFFF_8001.
- Conflict: mem_rvalid and alu_valid in the same cycle -> alu_ready=0, load written first; ALU written the following cycle.
- Full queue: issue 4 loads -> lq_count=4, ld_issue_ready=0. Issue plus response in the same cycle at count=3 -> count stays 3.
- Hazards:
  - Load rd=7 pending, chk_a=7 -> hazard_a=1.
  - chk_b=0 -> hazard_b=0.
  - hazard_a stays 1 until the cycle after the write, then drops.
- Reset/error: reset=0 with 2 loads queued -> lq_count=0, reg_we=0. A subsequent mem_rvalid -> err_unexpected=1, no write.
